// File: rtl/clock_tick_scheduler.sv
// One-second time base with seconds/minutes/hours carry chain and RUN/SET front-panel mode FSM.
// All outputs are registered; tick strobes coincide with the updated counts.
module clock_tick_scheduler #(
    parameter int TICK_DIVIDE    = 100000000,
    parameter int PRESCALE_WIDTH = 27
) (
    input  logic       cmosClock,
    input  logic       resetN,
    input  logic       modeStep,
    input  logic       incStep,
    output logic [5:0] seconds,
    output logic [5:0] minutes,
    output logic [4:0] hours,
    output logic       secTick,
    output logic       minTick,
    output logic       hourTick,
    output logic [1:0] mode,
    output logic       blink
);

    typedef enum logic [1:0] {
        RUN        = 2'b00,
        SET_HOUR   = 2'b01,
        SET_MINUTE = 2'b10
    } mode_t;

    localparam logic [PRESCALE_WIDTH-1:0] PRESCALE_LAST = PRESCALE_WIDTH'(TICK_DIVIDE - 1);
    localparam logic [PRESCALE_WIDTH-1:0] PRESCALE_HALF = PRESCALE_WIDTH'(TICK_DIVIDE / 2);
    localparam logic [PRESCALE_WIDTH-1:0] PRESCALE_ONE  = PRESCALE_WIDTH'(1);

    mode_t                     state;
    mode_t                     next_state;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic [PRESCALE_WIDTH-1:0] prescale_next;
    logic                      sec_event;
    logic                      clear_prescale;
    logic                      run_tick;
    logic                      sec_wrap;
    logic                      min_wrap;
    logic [5:0]                sec_next;
    logic [5:0]                min_next;
    logic [4:0]                hour_next;

    always_ff @(posedge cmosClock or negedge resetN) begin
        if (!resetN) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (modeStep) begin
            case (state)
                RUN:        next_state = SET_HOUR;
                SET_HOUR:   next_state = SET_MINUTE;
                SET_MINUTE: next_state = RUN;
                default:    next_state = RUN;
            endcase
        end
    end

    always_comb begin
        mode = state;
    end

    // Entering SET_HOUR and returning to RUN both restart the second so the
    // first running second after a set is a full TICK_DIVIDE cycles.
    assign sec_event      = (prescale == PRESCALE_LAST);
    assign clear_prescale = modeStep && ((state == RUN) || (state == SET_MINUTE));
    assign prescale_next  = (sec_event || clear_prescale) ? '0 : prescale + PRESCALE_ONE;

    assign run_tick = (state == RUN) && sec_event;
    assign sec_wrap = run_tick && (seconds == 6'd59);
    assign min_wrap = sec_wrap && (minutes == 6'd59);

    // The second event is applied before the SET_HOUR entry clear, and a
    // mode step always wins over a simultaneous increment.
    always_comb begin
        sec_next  = seconds;
        min_next  = minutes;
        hour_next = hours;
        if (run_tick) begin
            sec_next = sec_wrap ? 6'd0 : seconds + 6'd1;
            if (sec_wrap) begin
                min_next = min_wrap ? 6'd0 : minutes + 6'd1;
            end
            if (min_wrap) begin
                hour_next = (hours == 5'd23) ? 5'd0 : hours + 5'd1;
            end
        end
        if (modeStep) begin
            if (state == RUN) begin
                sec_next = 6'd0;
            end
        end else if (incStep) begin
            if (state == SET_HOUR) begin
                hour_next = (hours == 5'd23) ? 5'd0 : hours + 5'd1;
            end else if (state == SET_MINUTE) begin
                min_next = (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
            end
        end
    end

    always_ff @(posedge cmosClock or negedge resetN) begin
        if (!resetN) begin
            prescale <= '0;
            seconds  <= 6'd0;
            minutes  <= 6'd0;
            hours    <= 5'd0;
            secTick  <= 1'b0;
            minTick  <= 1'b0;
            hourTick <= 1'b0;
            blink    <= 1'b1;
        end else begin
            prescale <= prescale_next;
            seconds  <= sec_next;
            minutes  <= min_next;
            hours    <= hour_next;
            secTick  <= run_tick;
            minTick  <= sec_wrap;
            hourTick <= min_wrap;
            blink    <= (prescale_next < PRESCALE_HALF);
        end
    end

endmodule

// File: tb/tb_clock_tick_scheduler.sv
// Self-checking bench: time-of-day model kept as seconds-since-midnight, compared every cycle,
// plus directed literal checks for tick rate, set sequence, rollover and async reset.
module tb_clock_tick_scheduler;

    localparam int TD = 10;

    logic       cmosClock = 1'b0;
    logic       resetN    = 1'b0;
    logic       modeStep  = 1'b0;
    logic       incStep   = 1'b0;
    logic [5:0] seconds;
    logic [5:0] minutes;
    logic [4:0] hours;
    logic       secTick;
    logic       minTick;
    logic       hourTick;
    logic [1:0] mode;
    logic       blink;

    int total = 0;
    int bad   = 0;

    int mTod;
    int mPhase;
    int mMode;
    int mSec;
    int mMin;
    int mHour;

    always #5 cmosClock = ~cmosClock;

    clock_tick_scheduler #(
        .TICK_DIVIDE(TD),
        .PRESCALE_WIDTH(4)
    ) dut (
        .cmosClock(cmosClock),
        .resetN(resetN),
        .modeStep(modeStep),
        .incStep(incStep),
        .seconds(seconds),
        .minutes(minutes),
        .hours(hours),
        .secTick(secTick),
        .minTick(minTick),
        .hourTick(hourTick),
        .mode(mode),
        .blink(blink)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        mTod   = 0;
        mPhase = 0;
        mMode  = 0;
        mSec   = 0;
        mMin   = 0;
        mHour  = 0;
    endtask

    // Model of one rising edge: time is seconds since midnight, phase is position within the second.
    task automatic modelEdge();
        int h;
        int m;
        int s;
        mSec   = 0;
        mMin   = 0;
        mHour  = 0;
        mPhase = (mPhase + 1) % TD;
        if (mMode == 0 && mPhase == 0) begin
            mTod = (mTod + 1) % 86400;
            mSec = 1;
            mMin = (mTod % 60 == 0) ? 1 : 0;
            mHour = (mTod % 3600 == 0) ? 1 : 0;
        end
        h = mTod / 3600;
        m = (mTod / 60) % 60;
        s = mTod % 60;
        if (modeStep) begin
            if (mMode == 0) begin
                mTod   = mTod - s;
                mPhase = 0;
                mMode  = 1;
            end else if (mMode == 1) begin
                mMode = 2;
            end else begin
                mPhase = 0;
                mMode  = 0;
            end
        end else if (incStep) begin
            if (mMode == 1) mTod = ((h + 1) % 24) * 3600 + m * 60 + s;
            else if (mMode == 2) mTod = h * 3600 + ((m + 1) % 60) * 60 + s;
        end
    endtask

    task automatic compareAll();
        checkOutput("seconds", seconds, mTod % 60);
        checkOutput("minutes", minutes, (mTod / 60) % 60);
        checkOutput("hours", hours, mTod / 3600);
        checkOutput("secTick", secTick, mSec);
        checkOutput("minTick", minTick, mMin);
        checkOutput("hourTick", hourTick, mHour);
        checkOutput("mode", mode, mMode);
        checkOutput("blink", blink, (mPhase < TD / 2) ? 1 : 0);
    endtask

    task automatic cycle();
        @(posedge cmosClock);
        if (resetN) modelEdge();
        else modelReset();
        @(negedge cmosClock);
        compareAll();
    endtask

    task automatic applyStimulus(input logic ms, input logic inc);
        modeStep = ms;
        incStep  = inc;
        cycle();
        modeStep = 1'b0;
        incStep  = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [10:1] blinkExp;
        int firstTick;
        int found;
        blinkExp = 10'b1000001111;
        modelReset();
        @(negedge cmosClock);
        @(negedge cmosClock);
        compareAll();
        checkOutput("reset_blink", blink, 1);
        checkOutput("reset_mode", mode, 0);
        resetN = 1'b1;

        // Tick rate after reset release
        for (int k = 1; k <= 30; k++) begin
            cycle();
            if (k <= 10) checkOutput("blink_pattern", blink, blinkExp[k]);
            if (k % 10 == 0) begin
                checkOutput("tick_edge", secTick, 1);
                checkOutput("tick_seconds", seconds, k / 10);
            end
        end

        // Set sequence
        applyStimulus(1, 0);
        checkOutput("set_mode_hour", mode, 1);
        checkOutput("set_seconds_clear", seconds, 0);
        repeat (25) applyStimulus(0, 1);
        checkOutput("set_hours_wrap", hours, 1);
        applyStimulus(1, 0);
        checkOutput("set_mode_minute", mode, 2);
        repeat (61) applyStimulus(0, 1);
        checkOutput("set_minutes_wrap", minutes, 1);
        checkOutput("set_hours_kept", hours, 1);
        applyStimulus(1, 0);
        checkOutput("set_mode_run", mode, 0);
        firstTick = 0;
        for (int k = 1; k <= 12; k++) begin
            cycle();
            if (secTick && firstTick == 0) firstTick = k;
        end
        checkOutput("first_tick_after_set", firstTick, 10);

        // Preload 23:59 and run into midnight
        applyStimulus(1, 0);
        repeat (22) applyStimulus(0, 1);
        applyStimulus(1, 0);
        repeat (58) applyStimulus(0, 1);
        applyStimulus(1, 0);
        repeat (590) cycle();
        checkOutput("pre_roll_hours", hours, 23);
        checkOutput("pre_roll_minutes", minutes, 59);
        checkOutput("pre_roll_seconds", seconds, 59);
        repeat (10) cycle();
        checkOutput("roll_time", {hours, minutes, seconds}, 0);
        checkOutput("roll_ticks", {secTick, minTick, hourTick}, 3'b111);
        cycle();
        checkOutput("roll_ticks_done", {secTick, minTick, hourTick}, 3'b000);

        // Simultaneous mode and inc in SET_HOUR
        applyStimulus(1, 0);
        repeat (5) applyStimulus(0, 1);
        applyStimulus(1, 1);
        checkOutput("simul_mode", mode, 2);
        checkOutput("simul_hours", hours, 5);
        applyStimulus(1, 0);

        // Mode step coincident with the second event that reaches 7
        repeat (69) cycle();
        checkOutput("coinc_pre_seconds", seconds, 6);
        applyStimulus(1, 0);
        checkOutput("coinc_secTick", secTick, 1);
        checkOutput("coinc_mode", mode, 1);
        checkOutput("coinc_seconds", seconds, 0);
        applyStimulus(1, 0);
        applyStimulus(1, 0);

        // Asynchronous reset while a strobe is high
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            cycle();
            if (secTick) found = 1;
        end
        checkOutput("wait_tick", found, 1);
        #2 resetN = 1'b0;
        #1;
        modelReset();
        checkOutput("async_counts", {hours, minutes, seconds}, 0);
        checkOutput("async_ticks", {secTick, minTick, hourTick}, 0);
        checkOutput("async_mode", mode, 0);
        checkOutput("async_blink", blink, 1);
        cycle();
        resetN = 1'b1;

        // Randomised front-panel activity
        repeat (3000) begin
            int r;
            r = $urandom_range(0, 199);
            if (r == 199) begin
                resetN = 1'b0;
                modelReset();
                #1 compareAll();
                cycle();
                resetN = 1'b1;
            end else begin
                applyStimulus(r < 6, (r < 2) || (r >= 6 && r < 40));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
